// File: rtl/detector_emulator_pkg.sv
// Shared types for the detector emulator: FSM states and the configuration latched per accepted trigger.
// DETECTOR_EMU_SYNC_EN puts a 2-flop synchronizer in front of the trigger edge detector.
package detector_emulator_pkg;

  localparam int unsigned DE_CNT_W = 32;

`ifdef DETECTOR_EMU_SYNC_EN
  localparam int unsigned DE_SYNC_STAGES = 2;
`else
  localparam int unsigned DE_SYNC_STAGES = 0;
`endif

  typedef enum logic [1:0] {
    DE_IDLE,
    DE_DELAY,
    DE_READY,
    DE_DEAD
  } det_emu_state_t;

  typedef struct packed {
    logic [DE_CNT_W-1:0] readyDelay;
    logic [DE_CNT_W-1:0] readyLen;
    logic [DE_CNT_W-1:0] deadTime;
  } det_emu_cfg_t;

endpackage

// File: rtl/detector_emulator_rise_edge_detect.sv
// Turns the trigger level into a one-cycle rise pulse; with DETECTOR_EMU_SYNC_EN the level is
// first resynchronized through two flops.
module detector_emulator_rise_edge_detect
  import detector_emulator_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic level_i,
  output logic rise_o
);

  localparam int unsigned ARM_W = DE_SYNC_STAGES + 1;

  logic             sampled;
  logic             prev_q;
  logic [ARM_W-1:0] arm_q;

`ifdef DETECTOR_EMU_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], level_i};
    end
  end

  assign sampled = sync_q[1];
`else
  assign sampled = level_i;
`endif

  // The arm shift register masks rises until the sampling pipeline holds post-reset data,
  // so a trigger already high when reset releases is not mistaken for an edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      prev_q <= 1'b0;
      arm_q  <= '0;
    end else begin
      prev_q <= sampled;
      arm_q  <= (arm_q << 1) | ARM_W'(1);
    end
  end

  assign rise_o = sampled & ~prev_q & arm_q[ARM_W-1];

endmodule

// File: rtl/detector_emulator.sv
// Detector-side responder for the calibration trigger/ready handshake: programmable delay, ready
// length and dead time, with saturating accepted/missed counts. DETECTOR_EMU_SYNC_EN adds a 2-flop sync.
module detector_emulator
  import detector_emulator_pkg::*;
#(
  parameter int unsigned CNT_W  = DE_CNT_W,
  parameter int unsigned STAT_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              trigger_in,
  input  logic [CNT_W-1:0]  ready_delay,
  input  logic [CNT_W-1:0]  ready_len,
  input  logic [CNT_W-1:0]  dead_time,
  output logic              detector_ready,
  output logic              busy,
  output logic [STAT_W-1:0] trigger_count,
  output logic [STAT_W-1:0] missed_count
);

  det_emu_state_t      state_q, state_d;
  det_emu_cfg_t        cfg_q, cfg_d;
  logic [DE_CNT_W-1:0] cnt_q, cnt_d;
  logic [DE_CNT_W-1:0] cntInc;
  logic                ready_q, ready_d;
  logic [STAT_W-1:0]   trigCount_q, trigCount_d;
  logic [STAT_W-1:0]   missCount_q, missCount_d;
  logic                rise;

  detector_emulator_rise_edge_detect u_rise (
    .clock   (clock),
    .reset   (reset),
    .level_i (trigger_in),
    .rise_o  (rise)
  );

  assign cntInc = cnt_q + DE_CNT_W'(1);

  // One up-counter times every phase; it restarts at zero on each state change.
  always_comb begin
    state_d     = state_q;
    cfg_d       = cfg_q;
    cnt_d       = cnt_q;
    ready_d     = ready_q;
    trigCount_d = trigCount_q;
    missCount_d = missCount_q;

    if (!enable) begin
      state_d = DE_IDLE;
      ready_d = 1'b0;
      cnt_d   = '0;
    end else begin
      if (rise && (state_q != DE_IDLE) && (missCount_q != '1)) begin
        missCount_d = missCount_q + STAT_W'(1);
      end

      unique case (state_q)
        DE_IDLE: begin
          if (rise) begin
            cfg_d.readyDelay = DE_CNT_W'(ready_delay);
            cfg_d.readyLen   = DE_CNT_W'(ready_len);
            cfg_d.deadTime   = DE_CNT_W'(dead_time);
            if (trigCount_q != '1) begin
              trigCount_d = trigCount_q + STAT_W'(1);
            end
            state_d = DE_DELAY;
            cnt_d   = '0;
          end
        end
        DE_DELAY: begin
          if (cnt_q == cfg_q.readyDelay) begin
            state_d = DE_READY;
            ready_d = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cntInc;
          end
        end
        // A zero length still leaves ready high for one cycle.
        DE_READY: begin
          if (cntInc >= cfg_q.readyLen) begin
            ready_d = 1'b0;
            cnt_d   = '0;
            state_d = (cfg_q.deadTime == '0) ? DE_IDLE : DE_DEAD;
          end else begin
            cnt_d = cntInc;
          end
        end
        DE_DEAD: begin
          if (cntInc == cfg_q.deadTime) begin
            state_d = DE_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cntInc;
          end
        end
        default: begin
          state_d = DE_IDLE;
          ready_d = 1'b0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= DE_IDLE;
      cfg_q       <= '0;
      cnt_q       <= '0;
      ready_q     <= 1'b0;
      trigCount_q <= '0;
      missCount_q <= '0;
    end else begin
      state_q     <= state_d;
      cfg_q       <= cfg_d;
      cnt_q       <= cnt_d;
      ready_q     <= ready_d;
      trigCount_q <= trigCount_d;
      missCount_q <= missCount_d;
    end
  end

  assign detector_ready = ready_q;
  assign busy           = (state_q != DE_IDLE);
  assign trigger_count  = trigCount_q;
  assign missed_count   = missCount_q;

endmodule
